// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Segment bit order is a..g in bits 0..6, dp in bit 7, active-high.
package seg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [7:0] HEX_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F,
        8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C,
        8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/hex_to_seg.sv
// Pure combinational hex digit to 7-segment decoder; dp is always off.
// Zero latency, no state.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = HEX_TABLE[hex];

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 7-segment display; each grant dwells HOLD_CYCLES clocks.
// Outputs come only from registers: a request sampled at edge k is shown after edge k.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0][3:0] digit,
    output logic [NREQ-1:0]      grant,
    output logic [7:0]           seg,
    output logic [NREQ-1:0]      ack,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   last_q,  last_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [3:0]        digit_q, digit_d;

    logic [NREQ-1:0]   pick;
    logic [3:0]        pick_digit;
    logic              dwell_done;
    logic              repick;
    logic [7:0]        seg_dec;

    // Search starts just after the previous owner and ends on it, so a lone
    // requester can win again.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [NREQ-1:0] last);
        logic [NREQ-1:0] res;
        logic            found;
        int              base;
        int              idx;
        res   = '0;
        found = 1'b0;
        base  = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (last[i]) base = i;
        end
        for (int k = 1; k <= NREQ; k++) begin
            idx = (base + k) % NREQ;
            if (!found && r[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        pick       = rr_pick(req, last_q);
        pick_digit = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_digit = digit[i];
        end
    end

    assign dwell_done = (state_q == SHOW) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        repick  = 1'b0;

        case (state_q)
            IDLE: repick = 1'b1;
            SHOW: begin
                // Owner withdrawing early forfeits the rest of its dwell.
                if (dwell_done || ((req & grant_q) == '0)) begin
                    repick = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: repick = 1'b1;
        endcase

        if (repick) begin
            cnt_d = '0;
            if (|req) begin
                state_d = SHOW;
                grant_d = pick;
                last_d  = pick;
                digit_d = pick_digit;
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= {1'b1, {(NREQ-1){1'b0}}};
            cnt_q   <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    hex_to_seg u_hex_to_seg (
        .hex (digit_q),
        .seg (seg_dec)
    );

    assign grant = grant_q;
    assign busy  = (state_q == SHOW);
    assign seg   = busy ? seg_dec : SEG_BLANK;
    assign ack   = dwell_done ? grant_q : '0;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: main instance with HOLD_CYCLES=4 and a
// second instance with HOLD_CYCLES=1 sharing the same stimulus.
module tb_seg_display_arbiter;

    logic            clk_2 = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic [3:0][3:0] digit;
    logic [3:0]      grant, ack, grant1, ack1;
    logic [7:0]      seg, seg1;
    logic            busy, busy1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk_2 = ~clk_2;

    seg_display_arbiter #(.NREQ(4), .HOLD_CYCLES(4), .CNT_W(8)) u_dut (
        .clk_2 (clk_2), .reset (reset), .req (req), .digit (digit),
        .grant (grant), .seg (seg), .ack (ack), .busy (busy)
    );

    seg_display_arbiter #(.NREQ(4), .HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk_2 (clk_2), .reset (reset), .req (req), .digit (digit),
        .grant (grant1), .seg (seg1), .ack (ack1), .busy (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [7:0] s,
                              input logic [3:0] a, input logic b);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".seg"},   32'(seg),   32'(s));
        check({tag, ".ack"},   32'(ack),   32'(a));
        check({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] rr_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] rr_seg   [5] = '{8'h06, 8'h5B, 8'h66, 8'h7F, 8'h06};

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        digit = '0;

        // 1: reset and idle
        tick();
        tick();
        expect_out("rst", 4'b0000, 8'h00, 4'b0000, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("idle", 4'b0000, 8'h00, 4'b0000, 1'b0);
        end

        // 2: single requester, back-to-back regrant
        digit[0] = 4'h3;
        req      = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            tick();
            expect_out("solo", 4'b0001, 8'h4F, (c == 4) ? 4'b0001 : 4'b0000, 1'b1);
        end
        tick();
        expect_out("solo_regrant", 4'b0001, 8'h4F, 4'b0000, 1'b1);
        req = 4'b0000;
        tick();
        expect_out("solo_abort_idle", 4'b0000, 8'h00, 4'b0000, 1'b0);

        // 3: full rotation; HOLD_CYCLES=1 instance rotates every cycle
        do_reset();
        digit = {4'h8, 4'h4, 4'h2, 4'h1};
        req   = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                expect_out("rr", rr_grant[g], rr_seg[g],
                           (c == 4) ? rr_grant[g] : 4'b0000, 1'b1);
                check("h1.grant", 32'(grant1), 32'(4'b0001 << ((g * 4 + c - 1) % 4)));
                check("h1.ack",   32'(ack1),   32'(4'b0001 << ((g * 4 + c - 1) % 4)));
            end
        end

        // 4: owner drops early -> no ack, immediate handover; late drop still acks
        do_reset();
        digit = {4'h0, 4'h0, 4'h2, 4'h3};
        req   = 4'b0011;
        tick();
        expect_out("abort_c1", 4'b0001, 8'h4F, 4'b0000, 1'b1);
        tick();
        req = 4'b0010;
        expect_out("abort_c2", 4'b0001, 8'h4F, 4'b0000, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) req = 4'b0000;
            expect_out("handover", 4'b0010, 8'h5B, (c == 4) ? 4'b0010 : 4'b0000, 1'b1);
        end
        tick();
        expect_out("late_drop_idle", 4'b0000, 8'h00, 4'b0000, 1'b0);

        // 5: digit change mid-dwell only shows on the next grant
        do_reset();
        digit = {4'h0, 4'h0, 4'h0, 4'h3};
        req   = 4'b0001;
        tick();
        expect_out("latch_c1", 4'b0001, 8'h4F, 4'b0000, 1'b1);
        digit[0] = 4'hE;
        for (int c = 2; c <= 4; c++) begin
            tick();
            expect_out("latch_hold", 4'b0001, 8'h4F, (c == 4) ? 4'b0001 : 4'b0000, 1'b1);
        end
        tick();
        expect_out("latch_new", 4'b0001, 8'h79, 4'b0000, 1'b1);

        // 6: reset mid-dwell, then restart from req0
        do_reset();
        digit = {4'h0, 4'h5, 4'h0, 4'h9};
        req   = 4'b0100;
        tick();
        expect_out("mid_rst_c1", 4'b0100, 8'h6D, 4'b0000, 1'b1);
        tick();
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        expect_out("mid_rst", 4'b0000, 8'h00, 4'b0000, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("post_rst", 4'b0001, 8'h6F, 4'b0000, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Round-robin arbiter that shares the single 7-segment display (SEG) among NREQ requesters. Each requester presents a 4-bit hex digit and a request. The granted requester owns the display for a fixed dwell of HOLD_CYCLES clocks, then ownership rotates. The block sits between the requester logic in top and the SEG/LED pins; its one-hot grant vector drives LED[7:4].

Parameters:
NREQ, 4, number of requesters; grant and ack are one-hot over NREQ bits.
HOLD_CYCLES, 4, dwell length in clocks per grant; legal range 1..255.
CNT_W, 8, width of the dwell counter; must satisfy HOLD_CYCLES-1 < 2**CNT_W.

Ports:
clk_2  input  1  system clock; all state updates on posedge.
reset  input  1  reset, synchronous, active-high; clock clk_2.
req  input  NREQ  request per requester; level-sensitive.
digit  input  NREQ x 4 (packed [NREQ-1:0][3:0])  hex digit offered by each requester.
grant  output  NREQ  one-hot current owner; all zero when idle.
seg  output  8  segment pattern: bit0=a..bit6=g, bit7=dp; active-high.
ack  output  NREQ  one-hot pulse: granted requester's dwell completed normally.
busy  output  1  high while in SHOW.

Behaviour:
- State machine has two states, IDLE and SHOW. Registers: state, grant, last (one-hot round-robin pointer), cnt[CNT_W-1:0], latched digit.
- Reset values: state=IDLE, grant=0, last=one-hot bit NREQ-1 (so the first search starts at req0), cnt=0, seg=8'h00, ack=0, busy=0. Reset overrides every other event in the same cycle, including mid-dwell.
- Round-robin pick: search indices last+1, last+2, ... wrapping modulo NREQ, ending at last itself. The first index with req=1 wins. A sole requester can therefore win back-to-back.
- IDLE: if any req bit is 1 at an edge, go to SHOW on that edge. Load grant=pick, last=pick, cnt=0, latched digit=digit[pick]. Otherwise stay in IDLE with grant=0.
- Latency: a req sampled at edge k makes grant and seg valid after edge k. seg and grant are registered or derived from registers only; there is no combinational path from req or digit to any output.
- SHOW dwell: cnt increments by 1 each clock. seg=hex decode of the latched digit. A digit change after grant does not affect seg until the next grant.
- Normal end: when cnt==HOLD_CYCLES-1, ack=grant for that cycle (decoded from registers). At that edge, re-pick:
  - if any req is 1, stay in SHOW with the new grant, cnt=0, and a new latched digit; there is no idle gap;
  - otherwise go to IDLE with grant=0.
- Abort: if req[owner] falls to 0 while in SHOW before the final dwell cycle, the next edge re-picks exactly as at normal end. ack stays 0 for the aborted owner. req[owner]==0 in the final dwell cycle still produces ack.
- HOLD_CYCLES=1: every grant lasts exactly one cycle, and ack is high on every SHOW cycle.
- IDLE outputs: seg=8'h00 (blank), busy=0, ack=0.
- Hex table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; dp always 0.

Decomposition:
- Package seg_pkg holds:
  - the state enum (IDLE, SHOW);
  - SEG_BLANK=8'h00;
  - the 16-entry hex-to-segment constant table.
- Sub-module hex_to_seg is a pure combinational decoder, 4-bit in / 8-bit out, instantiated once on the latched digit.
- The round-robin pick is a function inside seg_display_arbiter and is not a separate module.

Test Plan:
1. Reset with reset=1 for 2 cycles, then reset=0 with req=0 -> grant=0000, seg=00, ack=0000, busy=0 on every cycle.
2. req=0001, digit0=3, HOLD_CYCLES=4 -> after 1 edge grant=0001, seg=4F for 4 cycles; ack=0001 on the 4th cycle; then immediate regrant to 0001 with no seg=00 gap.
3. req=1111, digits 1,2,4,8 -> grant sequence 0001,0010,0100,1000,0001 for 4 cycles each; seg sequence 06,5B,66,7F; ack pulses once per grant on its final cycle.
4. req=0011, then req[0] dropped on the 2nd cycle of its grant -> next edge grant=0010, cnt=0; no ack[0] at any point.
5. digit0 changed from 3 to E during a grant -> seg stays 4F until the dwell ends; the next grant to req0 shows 79.
6. Reset pulsed for 1 cycle on the 2nd cycle of a grant to req2 -> IDLE, seg=00, no ack; after release with req=1111, the first grant is 0001.
